score_hud: RTL and testbench

- Downstream consumer of the game-state block's `totalscore`, `lost` and `game_start` outputs.
- Converts the 11-bit binary score to four BCD digits with a sequential double-dabble engine.
- Tracks the session best score and raises a new-record flag.
- Generates a blink/blank strobe for the hex displays during game over.
- Feeds the hex-driver instances directly.

---
 rtl/score_hud.sv | 161 ++++++++++++++++
 tb/tb_score_hud.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/score_hud.sv
// Score HUD: sequential double-dabble BCD conversion of the live score,
// session best-score tracking and a game-over blink strobe for the hex displays.
module score_hud #(
    parameter int SCORE_W   = 11,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [SCORE_W-1:0] totalscore,
    input  logic               lost,
    input  logic               game_start,
    output logic [3:0]         hex_ones,
    output logic [3:0]         hex_tens,
    output logic [3:0]         hex_hund,
    output logic [3:0]         hex_thou,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_best,
    output logic               blank,
    output logic               busy
);

    localparam int CW = $clog2(SCORE_W + 1);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] conv_src_q, conv_src_d;
    logic [SCORE_W-1:0] src_q, src_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [15:0]        digits_q, digits_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               lost_d_q, lost_d_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic               new_best_q, new_best_d;
    logic [BW-1:0]      blink_q, blink_d;
    logic               blank_q, blank_d;
    logic [15:0]        adj;
    logic               change;
    logic               lost_rise;

    assign change    = (score_q != conv_src_q);
    assign lost_rise = lost & ~lost_d_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            score_q    <= '0;
            conv_src_q <= '0;
            src_q      <= '0;
            bcd_q      <= '0;
            digits_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            lost_d_q   <= 1'b0;
            best_q     <= '0;
            new_best_q <= 1'b0;
            blink_q    <= '0;
            blank_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            conv_src_q <= conv_src_d;
            src_q      <= src_d;
            bcd_q      <= bcd_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            lost_d_q   <= lost_d_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            blink_q    <= blink_d;
            blank_q    <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (change) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        score_d    = totalscore;
        conv_src_d = conv_src_q;
        src_d      = src_q;
        bcd_d      = bcd_q;
        digits_d   = digits_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                bcd_d = '0;
                cnt_d = CW'(SCORE_W);
                if (change) begin
                    conv_src_d = score_q;
                    src_d      = score_q;
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                bcd_d = {adj[14:0], src_q[SCORE_W-1]};
                src_d = src_q << 1;
                cnt_d = cnt_q - CW'(1);
            end
            DONE: begin
                digits_d = bcd_q;  // all four digits change on one edge
                busy_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        lost_d_d   = lost;
        best_d     = best_q;
        new_best_d = new_best_q;
        if (lost_rise && (score_q > best_q)) begin
            best_d     = score_q;
            new_best_d = 1'b1;
        end
        if (game_start) new_best_d = 1'b0;

        blink_d = blink_q;
        blank_d = blank_q;
        if (!lost) begin
            blink_d = '0;
            blank_d = 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            blank_d = ~blank_q;
        end else begin
            blink_d = blink_q + BW'(1);
        end
    end

    assign hex_ones   = digits_q[3:0];
    assign hex_tens   = digits_q[7:4];
    assign hex_hund   = digits_q[11:8];
    assign hex_thou   = digits_q[15:12];
    assign best_score = best_q;
    assign new_best   = new_best_q;
    assign blank      = blank_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_score_hud.sv
// Bench for score_hud: expected digit sets are queued by the stimulus and
// popped by a monitor on each conversion completion; side outputs checked inline.
module tb_score_hud;

    localparam int SCORE_W   = 11;
    localparam int BLINK_DIV = 4;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic [SCORE_W-1:0] totalscore = '0;
    logic               lost = 1'b0;
    logic               game_start = 1'b0;
    logic [3:0]         hex_ones, hex_tens, hex_hund, hex_thou;
    logic [SCORE_W-1:0] best_score;
    logic               new_best, blank, busy;

    int vectors = 0;
    int errs    = 0;
    logic [15:0] sb[$];
    logic        busy_seen;

    score_hud #(.SCORE_W(SCORE_W), .BLINK_DIV(BLINK_DIV)) dut (
        .Clk(Clk), .Reset(Reset), .totalscore(totalscore), .lost(lost),
        .game_start(game_start), .hex_ones(hex_ones), .hex_tens(hex_tens),
        .hex_hund(hex_hund), .hex_thou(hex_thou), .best_score(best_score),
        .new_best(new_best), .blank(blank), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Monitor: digits may only move on a busy falling edge, and must then match the queue head.
    logic        prev_busy = 1'b0;
    logic [15:0] prev_dig = '0;
    always @(negedge Clk) begin
        logic [15:0] dig;
        logic [15:0] exp_v;
        dig = {hex_thou, hex_hund, hex_tens, hex_ones};
        if (Reset) begin
            prev_busy = 1'b0;
            prev_dig  = dig;
        end else begin
            if (prev_busy && !busy) begin
                vectors++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL digits: conversion completed with %h but none expected", dig);
                end else begin
                    exp_v = sb.pop_front();
                    if (dig !== exp_v) begin
                        errs++;
                        $display("FAIL digits: got %h expected %h", dig, exp_v);
                    end
                end
            end else if (dig !== prev_dig) begin
                vectors++;
                errs++;
                $display("FAIL digits_stable: changed %h -> %h outside completion", prev_dig, dig);
            end
            prev_busy = busy;
            prev_dig  = dig;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_drain_timeout"}, (n < 200) ? 1 : 0, 1);
        tick();
    endtask

    task automatic wait_busy(input string nm);
        int n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        chk({nm, "_busy_rise"}, int'(busy), 1);
    endtask

    initial begin
        // Reset state and idle hold with score 0
        tick();
        tick();
        chk("rst_digits", int'({hex_thou, hex_hund, hex_tens, hex_ones}), 0);
        chk("rst_best", int'(best_score), 0);
        chk("rst_busy", int'(busy), 0);
        Reset = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        chk("idle_busy_never", int'(busy_seen), 0);
        chk("idle_best", int'(best_score), 0);
        chk("idle_blank", int'(blank), 0);
        chk("idle_new_best", int'(new_best), 0);

        // Latency: 0 -> 3 driven just after edge t
        totalscore = 11'd3;
        sb.push_back(16'h0003);
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk($sformatf("lat_busy_t%0d", k), int'(busy), (k >= 2 && k <= 13) ? 1 : 0);
        end
        chk("lat_ones", int'(hex_ones), 3);
        drain("lat");

        // Max value, then a change during the conversion
        totalscore = 11'd2047;
        sb.push_back(16'h2047);
        wait_busy("max");
        repeat (5) tick();
        totalscore = 11'd1234;
        sb.push_back(16'h1234);
        drain("max_then_1234");

        // First game: score 3, lost rises, blink
        totalscore = 11'd3;
        sb.push_back(16'h0003);
        drain("score3");
        lost = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) begin
                chk("g1_best", int'(best_score), 3);
                chk("g1_new_best", int'(new_best), 1);
            end
            chk($sformatf("blink_k%0d", k), int'(blank), (k / 4) % 2);
        end
        lost = 1'b0;
        tick();
        chk("blink_off", int'(blank), 0);

        // game_start clears the flag; equal and lower scores don't set a record
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        chk("start_clears_new_best", int'(new_best), 0);
        lost = 1'b1;
        tick();
        chk("g2_equal_best", int'(best_score), 3);
        chk("g2_equal_new_best", int'(new_best), 0);
        lost = 1'b0;
        tick();
        totalscore = 11'd2;
        sb.push_back(16'h0002);
        drain("score2");
        lost = 1'b1;
        tick();
        chk("g3_lower_best", int'(best_score), 3);
        chk("g3_lower_new_best", int'(new_best), 0);
        lost = 1'b0;
        tick();

        // Record coinciding with game_start: best updates, flag stays clear
        totalscore = 11'd5;
        sb.push_back(16'h0005);
        drain("score5");
        lost = 1'b1;
        game_start = 1'b1;
        tick();
        chk("coinc_best", int'(best_score), 5);
        chk("coinc_new_best", int'(new_best), 0);
        lost = 1'b0;
        game_start = 1'b0;
        tick();

        // Reset mid-conversion of 999
        totalscore = 11'd999;
        wait_busy("r999");
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        chk("async_rst_digits", int'({hex_thou, hex_hund, hex_tens, hex_ones}), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_best", int'(best_score), 0);
        tick();
        tick();
        sb.push_back(16'h0999);
        Reset = 1'b0;
        drain("after_rst_999");
        chk("after_rst_best", int'(best_score), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
